// File: rtl/spi_frame_rx_if.sv
// Pin-side and cache-write-side signal bundle for the serial frame receiver.
// Latency: none, wiring only.
// Backpressure: none; the SPI master simply must not clock frames while proc_en is high.
interface spi_frame_rx_if;
  logic       csi_n;
  logic       csd_n;
  logic       mosi;
  logic       proc_en;
  logic       wr_en_o;
  logic       wr_sel_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       frame_err_o;
  logic       busy_o;
  logic [7:0] frame_cnt_o;

  // Driver side: SPI master / run control, observes the cache write port.
  modport master (
    output csi_n, csd_n, mosi, proc_en,
    input  wr_en_o, wr_sel_o, wr_addr_o, wr_data_o, frame_err_o, busy_o, frame_cnt_o
  );

  // Receiver side.
  modport slave (
    input  csi_n, csd_n, mosi, proc_en,
    output wr_en_o, wr_sel_o, wr_addr_o, wr_data_o, frame_err_o, busy_o, frame_cnt_o
  );
endinterface

// File: rtl/spi_frame_rx.sv
// Deserialises LSB-first 12-bit {data,addr} frames into single-cycle icache/dcache write strobes.
// Latency: wr_en_o rises the cycle after the 12th sampling edge; bursts give one write per 12 cycles.
// Backpressure: none toward the pins; proc_en high locks out/aborts frames and flags frame_err_o.
module spi_frame_rx #(
  parameter int         FRAME_W   = 12,
  parameter logic [3:0] DMEM_LAST = 4'hE
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_frame_rx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

  state_t             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic [FRAME_W-1:0] shreg, shreg_nxt;
  logic               sel, sel_nxt;
  logic               commit;
  logic               err_nxt;

  // Select decode: exactly one chip select low starts a frame, both low is illegal.
  logic start_ok, start_bad, sel_act, other_act;
  assign start_ok  = !bus.proc_en && (bus.csi_n ^ bus.csd_n);
  assign start_bad = !bus.proc_en && !bus.csi_n && !bus.csd_n;
  assign sel_act   = sel ? !bus.csd_n : !bus.csi_n;
  assign other_act = sel ? !bus.csi_n : !bus.csd_n;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state, bit sampling and commit/error decisions.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    sel_nxt   = sel;
    commit    = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          sel_nxt      = bus.csi_n;  // csi_n high means csd_n is the one low
          shreg_nxt    = '0;
          shreg_nxt[0] = bus.mosi;
          cnt_nxt      = 4'd1;
          state_nxt    = SHIFT;
        end else if (start_bad) begin
          err_nxt   = 1'b1;
          cnt_nxt   = 4'd0;
          state_nxt = DRAIN;
        end
      end
      SHIFT: begin
        if (cnt == 4'd0) begin
          // Just committed a frame: a still-held select continues the burst
          // with no gap; anything else is judged exactly as from IDLE.
          if (start_ok) begin
            sel_nxt      = bus.csi_n;
            shreg_nxt    = '0;
            shreg_nxt[0] = bus.mosi;
            cnt_nxt      = 4'd1;
          end else if (start_bad) begin
            err_nxt   = 1'b1;
            state_nxt = DRAIN;
          end else begin
            state_nxt = IDLE;
          end
        end else if (other_act || bus.proc_en) begin
          // Collision or run request mid-frame: drop it and wait for the pins to clear.
          err_nxt   = 1'b1;
          cnt_nxt   = 4'd0;
          state_nxt = DRAIN;
        end else if (!sel_act) begin
          err_nxt   = 1'b1;
          cnt_nxt   = 4'd0;
          state_nxt = IDLE;
        end else begin
          shreg_nxt[cnt] = bus.mosi;
          if (cnt == LAST_BIT) begin
            cnt_nxt = 4'd0;
            // Address bits are already in shreg by now.
            if (sel && (shreg[3:0] > DMEM_LAST)) err_nxt = 1'b1;
            else                                 commit  = 1'b1;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      DRAIN: begin
        if (bus.csi_n && bus.csd_n && !bus.proc_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: bit counter, shift buffer, latched target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 4'd0;
      shreg <= '0;
      sel   <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
      sel   <= sel_nxt;
    end
  end

  // Registered outputs; write fields only change on a committed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_en_o     <= 1'b0;
      bus.wr_sel_o    <= 1'b0;
      bus.wr_addr_o   <= 4'd0;
      bus.wr_data_o   <= 8'd0;
      bus.frame_err_o <= 1'b0;
      bus.busy_o      <= 1'b0;
      bus.frame_cnt_o <= 8'd0;
    end else begin
      bus.wr_en_o     <= commit;
      bus.frame_err_o <= err_nxt;
      bus.busy_o      <= (state_nxt != IDLE);
      if (commit) begin
        bus.wr_sel_o    <= sel;
        bus.wr_addr_o   <= shreg_nxt[3:0];
        bus.wr_data_o   <= shreg_nxt[FRAME_W-1:4];
        bus.frame_cnt_o <= bus.frame_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: directed frames, expected strobes queued by the driver.
// A negedge monitor pops the queue on every wr_en_o/frame_err_o and checks cycle and contents.
// Pin-level state (busy, held fields, reset values) is checked inline.
module tb_spi_frame_rx;

  logic clk = 1'b0;
  logic rst_n;

  spi_frame_rx_if bus ();

  spi_frame_rx #(.FRAME_W(12), .DMEM_LAST(4'hE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit         is_err;
    bit         sel;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_cnt  = 8'd0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Queue the response expected in the current cycle (called #1 after the deciding edge).
  task automatic push_exp(input bit is_err, input bit s, input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.sel    = s;
    e.addr   = a;
    e.data   = d;
    if (!is_err) exp_cnt++;
    e.cnt = exp_cnt;
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.csi_n = 1'b1;
    bus.csd_n = 1'b1;
    bus.mosi  = 1'b0;
    repeat (n) step();
  endtask

  // Clock out the first nbits of a frame LSB-first; select is left asserted.
  task automatic drive_frame(input bit is_d, input logic [3:0] a, input logic [7:0] d, input int nbits);
    logic [11:0] f;
    f = {d, a};
    for (int i = 0; i < nbits; i++) begin
      bus.csi_n = is_d;
      bus.csd_n = !is_d;
      bus.mosi  = f[i];
      step();
    end
    if (nbits == 12) begin
      if (is_d && (a > 4'hE)) push_exp(1'b1, is_d, a, d);
      else                    push_exp(1'b0, is_d, a, d);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && (bus.wr_en_o || bus.frame_err_o)) begin
      chk("strobe_exclusive", int'(bus.wr_en_o & bus.frame_err_o), 0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: wr_en=%0d err=%0d at cycle %0d, none expected",
                 bus.wr_en_o, bus.frame_err_o, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("strobe_kind_err", int'(bus.frame_err_o), int'(mon_e.is_err));
        chk("strobe_cycle", cyc, mon_e.cyc);
        if (!mon_e.is_err) begin
          chk("wr_sel", int'(bus.wr_sel_o), int'(mon_e.sel));
          chk("wr_addr", int'(bus.wr_addr_o), int'(mon_e.addr));
          chk("wr_data", int'(bus.wr_data_o), int'(mon_e.data));
          chk("frame_cnt", int'(bus.frame_cnt_o), int'(mon_e.cnt));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"},     int'(bus.wr_en_o), 0);
    chk({tag, "_err"},       int'(bus.frame_err_o), 0);
    chk({tag, "_busy"},      int'(bus.busy_o), 0);
    chk({tag, "_frame_cnt"}, int'(bus.frame_cnt_o), 0);
    chk({tag, "_wr_addr"},   int'(bus.wr_addr_o), 0);
    chk({tag, "_wr_data"},   int'(bus.wr_data_o), 0);
    chk({tag, "_wr_sel"},    int'(bus.wr_sel_o), 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.csi_n   = 1'b1;
    bus.csd_n   = 1'b1;
    bus.mosi    = 1'b0;
    bus.proc_en = 1'b0;
    #12;
    chk_all_zero("reset");
    step();
    rst_n = 1'b1;
    idle(2);

    // Good icache frame: addr 3, data 0xA5.
    drive_frame(1'b0, 4'h3, 8'hA5, 12);
    idle(1);
    chk("icache_busy_after", int'(bus.busy_o), 0);
    idle(2);

    // Burst on dcache: two frames back to back, select held for 24 cycles.
    drive_frame(1'b1, 4'h0, 8'h11, 12);
    drive_frame(1'b1, 4'h1, 8'h22, 12);
    idle(3);

    // Abort: icache select released after 7 bits.
    drive_frame(1'b0, 4'h5, 8'h3C, 7);
    chk("abort_busy_mid", int'(bus.busy_o), 1);
    bus.csi_n = 1'b1;
    step();
    push_exp(1'b1, 1'b0, 4'h0, 8'h00);
    chk("abort_busy_after", int'(bus.busy_o), 0);
    chk("abort_frame_cnt", int'(bus.frame_cnt_o), int'(exp_cnt));
    idle(2);

    // Illegal select: both low from IDLE, DRAIN until released.
    bus.csi_n = 1'b0;
    bus.csd_n = 1'b0;
    step();
    push_exp(1'b1, 1'b0, 4'h0, 8'h00);
    repeat (3) step();
    chk("illegal_drain_busy", int'(bus.busy_o), 1);
    idle(1);
    chk("illegal_released_busy", int'(bus.busy_o), 0);
    idle(2);

    // Lockout: proc_en raised at bit 5, DRAIN held while any pin is active.
    drive_frame(1'b0, 4'h7, 8'h81, 5);
    bus.proc_en = 1'b1;
    step();
    push_exp(1'b1, 1'b0, 4'h0, 8'h00);
    repeat (2) step();
    chk("lockout_drain_cs", int'(bus.busy_o), 1);
    bus.csi_n = 1'b1;
    repeat (2) step();
    chk("lockout_drain_proc", int'(bus.busy_o), 1);
    bus.proc_en = 1'b0;
    step();
    chk("lockout_released_busy", int'(bus.busy_o), 0);
    idle(2);

    // proc_en high in IDLE: pins ignored entirely.
    bus.proc_en = 1'b1;
    bus.csi_n   = 1'b0;
    for (int i = 0; i < 14; i++) begin
      bus.mosi = i[0];
      step();
    end
    chk("proc_en_idle_busy", int'(bus.busy_o), 0);
    chk("proc_en_idle_cnt", int'(bus.frame_cnt_o), int'(exp_cnt));
    bus.proc_en = 1'b0;
    idle(2);

    // Rejected dcache address 0xF; write fields keep the last burst values.
    drive_frame(1'b1, 4'hF, 8'h7E, 12);
    idle(2);
    chk("reject_hold_addr", int'(bus.wr_addr_o), 1);
    chk("reject_hold_data", int'(bus.wr_data_o), 8'h22);
    chk("reject_hold_sel", int'(bus.wr_sel_o), 1);
    chk("reject_frame_cnt", int'(bus.frame_cnt_o), int'(exp_cnt));

    // Highest legal dcache address is accepted.
    drive_frame(1'b1, 4'hE, 8'h3C, 12);
    idle(3);

    // Reset mid-frame at bit 6: outputs clear at once, no error pulse.
    drive_frame(1'b0, 4'h2, 8'h99, 6);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_cnt = 8'd0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    drive_frame(1'b0, 4'h9, 8'h5A, 12);
    idle(3);

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
